// File: rtl/microwave_countdown_timer_pkg.sv
// Shared definitions for the microwave countdown timer.
// Holds the FSM state encoding, the BCD digit limits, the M:SS time
// record and the digit clamping helpers used when a new time is loaded.
package microwave_countdown_timer_pkg;

   // FSM state encoding (fixed, visible on the state output)
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOADED  = 3'd1;
   localparam logic [2:0] ST_RUNNING = 3'd2;
   localparam logic [2:0] ST_PAUSED  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Largest legal value of each BCD digit
   localparam logic [2:0] SEC_TENS_MAX  = 3'd5;
   localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
   localparam logic [2:0] MIN_MAX       = 3'd7;

   // Cooking time as M:SS digits
   typedef struct packed {
      logic [2:0] min;
      logic [2:0] tens;
      logic [3:0] units;
   } mmss_t;

   localparam mmss_t MMSS_ZERO = '{min: 3'd0, tens: 3'd0, units: 4'd0};

   // Out-of-range seconds-tens digits saturate at 5
   function automatic logic [2:0] clamp_tens(input logic [2:0] d);
      if (d > SEC_TENS_MAX) begin
         return SEC_TENS_MAX;
      end else begin
         return d;
      end
   endfunction

   // Out-of-range seconds-units digits saturate at 9
   function automatic logic [3:0] clamp_units(input logic [3:0] d);
      if (d > SEC_UNITS_MAX) begin
         return SEC_UNITS_MAX;
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/microwave_countdown_timer_bcd_mmss_decrement.sv
// Combinational one-second decrement of an M:SS BCD time.
// Ports:
//   min_cur/tens_cur/units_cur    : present time digits
//   min_next/tens_next/units_next : time one second earlier (0:00 holds)
//   is_one                        : present time is exactly 0:01
module bcd_mmss_decrement
   import microwave_countdown_timer_pkg::*;
(
   input  logic [2:0] min_cur,
   input  logic [2:0] tens_cur,
   input  logic [3:0] units_cur,
   output logic [2:0] min_next,
   output logic [2:0] tens_next,
   output logic [3:0] units_next,
   output logic       is_one
);

   logic is_zero_s;

   assign is_zero_s = (min_cur == 3'd0) && (tens_cur == 3'd0) && (units_cur == 4'd0);
   assign is_one    = (min_cur == 3'd0) && (tens_cur == 3'd0) && (units_cur == 4'd1);

   // Borrow chain units -> tens -> minutes; 0:00 saturates instead of wrapping
   always_comb begin
      min_next   = min_cur;
      tens_next  = tens_cur;
      units_next = units_cur;
      if (is_zero_s) begin
         min_next   = min_cur;
         tens_next  = tens_cur;
         units_next = units_cur;
      end else if (units_cur != 4'd0) begin
         units_next = units_cur - 4'd1;
      end else begin
         units_next = SEC_UNITS_MAX;
         if (tens_cur != 3'd0) begin
            tens_next = tens_cur - 3'd1;
         end else begin
            tens_next = SEC_TENS_MAX;
            min_next  = min_cur - 3'd1;
         end
      end
   end

endmodule

// File: rtl/microwave_countdown_timer.sv
// Microwave cooking-time countdown stage.
// Loads an M:SS BCD time, counts it down on the 1 Hz tick enable while
// RUNNING, gates the magnetron, and raises a tick-timed alarm on completion.
// Ports:
//   clk, reset                        : clock, async active-high reset
//   tick                              : one-cycle 1 Hz enable
//   min_in, sec_tens_in, sec_units_in : time to load (seconds clamped)
//   load, start, cancel, door_open    : controls (cancel > door > load > start > tick)
//   min_out, sec_tens_out, sec_units_out : current time
//   magnetron_on                      : heating enable (combinational door gating)
//   done                              : one-cycle completion pulse
//   alarm                             : buzzer enable
//   state                             : current FSM state
module microwave_countdown_timer
   import microwave_countdown_timer_pkg::*;
#(
   parameter int ALARM_TICKS = 3,
   parameter int STATE_W     = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [2:0]         min_in,
   input  logic [2:0]         sec_tens_in,
   input  logic [3:0]         sec_units_in,
   input  logic               load,
   input  logic               start,
   input  logic               cancel,
   input  logic               door_open,
   output logic [2:0]         min_out,
   output logic [2:0]         sec_tens_out,
   output logic [3:0]         sec_units_out,
   output logic               magnetron_on,
   output logic               done,
   output logic               alarm,
   output logic [STATE_W-1:0] state
);

   localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS);

   mmss_t      time_r, time_n;
   mmss_t      load_val_s;
   mmss_t      dec_s;
   logic [2:0] state_r, state_n;
   logic [3:0] alarm_cnt_r, alarm_cnt_n;
   logic       alarm_r, alarm_n;
   logic       done_r, done_n;
   logic       is_one_s;
   logic       load_ok_s;
   logic       start_ok_s;

   bcd_mmss_decrement u_dec (
      .min_cur    (time_r.min),
      .tens_cur   (time_r.tens),
      .units_cur  (time_r.units),
      .min_next   (dec_s.min),
      .tens_next  (dec_s.tens),
      .units_next (dec_s.units),
      .is_one     (is_one_s)
   );

   assign load_val_s.min   = min_in;
   assign load_val_s.tens  = clamp_tens(sec_tens_in);
   assign load_val_s.units = clamp_units(sec_units_in);

   // door_open only counts as an event in RUNNING and DONE, so it is tested
   // per state below; start additionally needs the door closed.
   assign load_ok_s  = load && ((state_r == ST_IDLE) || (state_r == ST_LOADED) ||
                                (state_r == ST_DONE));
   assign start_ok_s = start && !door_open &&
                       ((state_r == ST_LOADED) || (state_r == ST_PAUSED));

   // Next-state selection: only the highest-priority applicable event acts
   always_comb begin
      time_n      = time_r;
      state_n     = state_r;
      alarm_cnt_n = alarm_cnt_r;
      alarm_n     = alarm_r;
      done_n      = 1'b0;
      if (cancel) begin
         time_n      = MMSS_ZERO;
         state_n     = ST_IDLE;
         alarm_n     = 1'b0;
         alarm_cnt_n = 4'd0;
      end else if (door_open && (state_r == ST_RUNNING)) begin
         // coincident tick is dropped: digits hold
         state_n = ST_PAUSED;
      end else if (door_open && (state_r == ST_DONE)) begin
         state_n     = ST_IDLE;
         alarm_n     = 1'b0;
         alarm_cnt_n = 4'd0;
      end else if (load_ok_s) begin
         time_n      = load_val_s;
         alarm_n     = 1'b0;
         alarm_cnt_n = 4'd0;
         if (load_val_s != MMSS_ZERO) begin
            state_n = ST_LOADED;
         end else begin
            state_n = ST_IDLE;
         end
      end else if (start_ok_s) begin
         state_n = ST_RUNNING;
      end else if (tick && (state_r == ST_RUNNING)) begin
         time_n = dec_s;
         if (is_one_s) begin
            state_n     = ST_DONE;
            done_n      = 1'b1;
            alarm_n     = 1'b1;
            alarm_cnt_n = 4'd0;
         end else begin
            state_n = ST_RUNNING;
         end
      end else if (tick && (state_r == ST_DONE)) begin
         if ((alarm_cnt_r + 4'd1) == ALARM_LAST) begin
            state_n     = ST_IDLE;
            alarm_n     = 1'b0;
            alarm_cnt_n = 4'd0;
         end else begin
            alarm_cnt_n = alarm_cnt_r + 4'd1;
         end
      end else begin
         done_n = 1'b0;
      end
   end

   // State, time, alarm and done registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         time_r      <= MMSS_ZERO;
         state_r     <= ST_IDLE;
         alarm_cnt_r <= 4'd0;
         alarm_r     <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         time_r      <= time_n;
         state_r     <= state_n;
         alarm_cnt_r <= alarm_cnt_n;
         alarm_r     <= alarm_n;
         done_r      <= done_n;
      end
   end

   assign min_out       = time_r.min;
   assign sec_tens_out  = time_r.tens;
   assign sec_units_out = time_r.units;
   assign done          = done_r;
   assign alarm         = alarm_r;
   assign state         = STATE_W'(state_r);
   // Door opening cuts heating in the same cycle, before the state moves
   assign magnetron_on  = (state_r == ST_RUNNING) && !door_open;

endmodule
